// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } state_t;

    localparam int STRB_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin selector: first valid at or after the pointer, wrapping.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from farthest to nearest so the nearest valid overrides.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one sync-read RAM between NUM_REQ valid/ready requesters,
// round-robin, one access per cycle, one response outstanding.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int SW         = strb_w(DATA_WIDTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*SW-1:0]         req_wstrb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_raddr,
    output logic [ADDR_WIDTH-1:0]         ram_waddr,
    output logic [SW-1:0]                 ram_wstrb,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    localparam int IW = idx_w(NUM_REQ);

    state_t                state, state_n;
    logic [IW-1:0]         owner, owner_n;
    logic [IW-1:0]         ptr, ptr_n;
    logic [DATA_WIDTH-1:0] hold, hold_n;

    logic                  issue;
    logic [NUM_REQ-1:0]    gvalid;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         gidx;
    logic                  gany;

    // Reset gating keeps req_ready and ram_* quiet while reset is held.
    assign issue  = reset && ((state == IDLE) || resp_ready[owner]);
    assign gvalid = issue ? req_valid : '0;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid (gvalid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign req_ready = grant;
    assign ram_waddr = ram_raddr;

    always_comb begin
        ram_raddr = '0;
        ram_wstrb = '0;
        ram_wdata = '0;
        if (gany) begin
            ram_raddr = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wstrb = req_wstrb[int'(gidx)*SW +: SW];
            ram_wdata = req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        if (state != IDLE) begin
            resp_valid[owner] = 1'b1;
            resp_rdata = (state == HOLD) ? hold : ram_rdata;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold;
        unique case (state)
            IDLE: if (gany) state_n = RESP;
            RESP: begin
                if (resp_ready[owner]) begin
                    state_n = gany ? RESP : IDLE;
                end else begin
                    state_n = HOLD;
                    hold_n  = ram_rdata;
                end
            end
            HOLD: if (resp_ready[owner]) state_n = gany ? RESP : IDLE;
            default: state_n = IDLE;
        endcase
        if (gany) begin
            owner_n = gidx;
            ptr_n   = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scoreboard bench for ram_port_arbiter (2- and 3-port builds).
module tb_ram_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Two-requester instance
    logic [1:0]  rv2 = '0, gr2, rsp2, rr2 = 2'b11;
    logic [23:0] addr2 = '0;
    logic [7:0]  ws2 = '0;
    logic [63:0] wd2 = '0;
    logic [31:0] rdata2, ramrd2, wdata2;
    logic [11:0] raddr2, waddr2;
    logic [3:0]  wstrb2;

    ram_port_arbiter #(.NUM_REQ(2)) dut2 (
        .clock(clock), .reset(reset),
        .req_valid(rv2), .req_ready(gr2),
        .req_addr(addr2), .req_wstrb(ws2), .req_wdata(wd2),
        .resp_valid(rsp2), .resp_ready(rr2), .resp_rdata(rdata2),
        .ram_raddr(raddr2), .ram_waddr(waddr2), .ram_wstrb(wstrb2),
        .ram_wdata(wdata2), .ram_rdata(ramrd2)
    );

    // Three-requester instance (wrap test)
    logic [2:0]  rv3 = '0, gr3, rsp3, rr3 = 3'b111;
    logic [35:0] addr3 = '0;
    logic [11:0] ws3 = '0;
    logic [95:0] wd3 = '0;
    logic [31:0] rdata3, ramrd3, wdata3;
    logic [11:0] raddr3, waddr3;
    logic [3:0]  wstrb3;

    ram_port_arbiter #(.NUM_REQ(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(rv3), .req_ready(gr3),
        .req_addr(addr3), .req_wstrb(ws3), .req_wdata(wd3),
        .resp_valid(rsp3), .resp_ready(rr3), .resp_rdata(rdata3),
        .ram_raddr(raddr3), .ram_waddr(waddr3), .ram_wstrb(wstrb3),
        .ram_wdata(wdata3), .ram_rdata(ramrd3)
    );

    function automatic logic [31:0] pat(input int a);
        return 32'(a) * 32'h0101_0101 ^ 32'h5A5A_5A5A;
    endfunction

    // RAM macros: sync read, byte-enable write, read-before-write
    logic [31:0] mem2 [4096];
    logic [31:0] mem3 [4096];
    logic [31:0] refm [4096];

    always @(posedge clock) begin
        ramrd2 <= mem2[raddr2];
        for (int b = 0; b < 4; b++)
            if (wstrb2[b]) mem2[waddr2][b*8 +: 8] <= wdata2[b*8 +: 8];
        ramrd3 <= mem3[raddr3];
        for (int b = 0; b < 4; b++)
            if (wstrb3[b]) mem3[waddr3][b*8 +: 8] <= wdata3[b*8 +: 8];
    end

    typedef struct {
        int          who;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard one cycle of dut2, then advance to posedge+1.
    task automatic cyc();
        int g;
        logic [11:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        if (q.size() > 0) begin
            chk("resp_valid", 32'(rsp2), 32'(1) << q[0].who);
            chk("resp_rdata", rdata2, q[0].data);
            if (rr2[q[0].who]) void'(q.pop_front());
        end else begin
            chk("idle_resp_valid", 32'(rsp2), 0);
            chk("idle_resp_rdata", rdata2, 0);
        end
        chk("ready_subset", 32'(gr2 & ~rv2), 0);
        if (gr2 != 0) begin
            g = gr2[1] ? 1 : 0;
            a = addr2[g*12 +: 12];
            s = ws2[g*4 +: 4];
            d = wd2[g*32 +: 32];
            chk("ram_raddr", 32'(raddr2), 32'(a));
            chk("ram_waddr", 32'(waddr2), 32'(a));
            chk("ram_wstrb", 32'(wstrb2), 32'(s));
            if (s != 0) chk("ram_wdata", wdata2, d);
            q.push_back('{who: g, data: refm[a]});
            for (int b = 0; b < 4; b++)
                if (s[b]) refm[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            chk("nogrant_wstrb", 32'(wstrb2), 0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem2[i] = pat(i);
            mem3[i] = pat(i);
            refm[i] = pat(i);
        end
        mem2[12'h010] = 32'hDEAD_BEEF;
        refm[12'h010] = 32'hDEAD_BEEF;
        mem2[12'h020] = 32'hAABB_CCDD;
        refm[12'h020] = 32'hAABB_CCDD;

        // Reset state, with requests asserted
        rv2 = 2'b11;
        addr2 = {12'h020, 12'h010};
        #3;
        chk("rst_req_ready", 32'(gr2), 0);
        chk("rst_resp_valid", 32'(rsp2), 0);
        chk("rst_resp_rdata", rdata2, 0);
        chk("rst_ram_wstrb", 32'(wstrb2), 0);
        chk("rst_ram_raddr", 32'(raddr2), 0);
        chk("rst_ram_wdata", wdata2, 0);
        rv2 = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: single read
        rv2 = 2'b01;
        addr2[11:0] = 12'h010;
        #1;
        chk("t1_ready", 32'(gr2), 32'b01);
        cyc();
        rv2 = '0;
        #1;
        chk("t1_rdata", rdata2, 32'hDEAD_BEEF);
        cyc();
        #1;
        cyc();

        // 2: byte write then read-back
        rv2 = 2'b10;
        addr2[23:12] = 12'h020;
        ws2[7:4] = 4'b0101;
        wd2[63:32] = 32'h1122_3344;
        #1;
        chk("t2_ready", 32'(gr2), 32'b10);
        cyc();
        rv2 = '0;
        ws2 = '0;
        #1;
        chk("t2_old", rdata2, 32'hAABB_CCDD);
        cyc();
        rv2 = 2'b10;
        #1;
        cyc();
        rv2 = '0;
        #1;
        chk("t2_new", rdata2, 32'hAA22_CC44);
        cyc();

        // 3: contention, pointer now 0
        rv2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_alt", 32'(gr2), (k % 2 == 0) ? 32'b01 : 32'b10);
            cyc();
        end
        rv2 = '0;
        #1;
        cyc();

        // 4: backpressure on requester 0
        rv2 = 2'b01;
        #1;
        chk("t4_grant0", 32'(gr2), 32'b01);
        cyc();
        rr2 = 2'b10;
        rv2 = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_blocked", 32'(gr2), 0);
            chk("t4_hold", rdata2, 32'hDEAD_BEEF);
            cyc();
        end
        rr2 = 2'b11;
        #1;
        chk("t4_accept_grant1", 32'(gr2), 32'b10);
        cyc();
        rv2 = '0;
        #1;
        cyc();
        #1;
        cyc();

        // 5: reset while a response is pending
        rv2 = 2'b01;
        #1;
        cyc();
        rv2 = 2'b11;
        #1;
        chk("t5_pending", 32'(rsp2), 32'b01);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(rsp2), 0);
        chk("t5_rst_rdata", rdata2, 0);
        chk("t5_rst_ready", 32'(gr2), 0);
        chk("t5_rst_wstrb", 32'(wstrb2), 0);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_ptr0", 32'(gr2), 32'b01);
        chk("t5_no_stale", 32'(rsp2), 0);
        cyc();
        rv2 = '0;
        #1;
        cyc();
        #1;
        cyc();

        // 6: wrap on the 3-port build
        addr3 = {12'h007, 12'h006, 12'h005};
        rv3 = 3'b010;
        #1;
        chk("t6_first", 32'(gr3), 32'b010);
        @(posedge clock);
        #1;
        rv3 = 3'b011;
        #1;
        chk("t6_rsp1", 32'(rsp3), 32'b010);
        chk("t6_rdata1", rdata3, pat(6));
        chk("t6_wrap0", 32'(gr3), 32'b001);
        @(posedge clock);
        #1;
        #1;
        chk("t6_rsp0", 32'(rsp3), 32'b001);
        chk("t6_rdata0", rdata3, pat(5));
        chk("t6_then1", 32'(gr3), 32'b010);
        @(posedge clock);
        #1;
        rv3 = '0;
        #1;
        chk("t6_rsp_last", 32'(rsp3), 32'b010);
        @(posedge clock);
        #1;
        chk("t6_idle", 32'(rsp3), 0);

        chk("sb_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
